// File: rtl/cmp_arbiter.sv
// ============================================================================
// Module   : cmp_arbiter (+ comparator)
// Purpose  : Round-robin sharing of one comparator between NUM_REQ requesters.
//            Define CMP_ARB_SIGNED_EN for a two's-complement compare.
// Revision : 1.0
// ============================================================================
`default_nettype none

module comparator #(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic            is_a_greater,
    output logic            equal
);
    assign is_a_greater = (a > b);
    assign equal        = (a == b);
endmodule

module cmp_arbiter #(
    parameter  int SIZE    = 8,
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*SIZE-1:0] req_a,
    input  logic [NUM_REQ*SIZE-1:0] req_b,
    output logic [NUM_REQ-1:0]      req_ack,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    rsp_gt,
    output logic                    rsp_eq,
    output logic                    busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   cand;
    logic              found;
    logic [SIZE-1:0]   op_a;
    logic [SIZE-1:0]   op_b;
    logic [SIZE-1:0]   cmp_a;
    logic [SIZE-1:0]   cmp_b;
    logic              cmp_gt;
    logic              cmp_eq;

    // Search upward from the requester after the last grant, wrapping at NUM_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

`ifdef CMP_ARB_SIGNED_EN
    // Flipping the sign bit maps two's complement onto unsigned ordering.
    assign cmp_a = {~op_a[SIZE-1], op_a[SIZE-2:0]};
    assign cmp_b = {~op_b[SIZE-1], op_b[SIZE-2:0]};
`else
    assign cmp_a = op_a;
    assign cmp_b = op_b;
`endif

    comparator #(
        .SIZE (SIZE)
    ) u_comparator (
        .a            (cmp_a),
        .b            (cmp_b),
        .is_a_greater (cmp_gt),
        .equal        (cmp_eq)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (found) begin
                    state_next = S_COMPARE;
                end
            end
            S_COMPARE: begin
                state_next = S_RESPOND;
            end
            S_RESPOND: begin
                if (rsp_valid && rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= ID_W'(NUM_REQ - 1);
            op_a       <= '0;
            op_b       <= '0;
            req_ack    <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_gt     <= 1'b0;
            rsp_eq     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            busy    <= (state_next != S_IDLE);
            req_ack <= '0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        op_a       <= req_a[int'(winner)*SIZE +: SIZE];
                        op_b       <= req_b[int'(winner)*SIZE +: SIZE];
                        rsp_id     <= winner;
                        last_grant <= winner;
                        req_ack    <= NUM_REQ'(1) << winner;
                    end
                end
                S_COMPARE: begin
                    rsp_gt    <= cmp_gt;
                    rsp_eq    <= cmp_eq;
                    rsp_valid <= 1'b1;
                end
                S_RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cmp_arbiter.sv
// ============================================================================
// Module   : tb_cmp_arbiter
// Purpose  : Directed self-checking bench for cmp_arbiter (SIZE=8, NUM_REQ=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cmp_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ack;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic        rsp_gt;
    logic        rsp_eq;
    logic        busy;

    int tests = 0;
    int fails = 0;

    cmp_arbiter #(
        .SIZE    (8),
        .NUM_REQ (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ack   (req_ack),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_gt    (rsp_gt),
        .rsp_eq    (rsp_eq),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n     = 1'b0;
        req       = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req   = '0;
        #2;
        tests++;
        if ({req_ack, rsp_valid, rsp_id, rsp_gt, rsp_eq, busy} !== 10'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b expected %b",
                     {req_ack, rsp_valid, rsp_id, rsp_gt, rsp_eq, busy}, 10'b0);
        end
        apply_reset();
        tests++;
        if ({req_ack, rsp_valid, busy} !== 6'b0) begin
            fails++;
            $display("FAIL reset_idle: got %b expected %b", {req_ack, rsp_valid, busy}, 6'b0);
        end
    endtask

    // Single-request transactions: grant, result, return to idle.
    task automatic test_compare;
        logic [1:0] ids [5] = '{2'd2, 2'd0, 2'd1, 2'd3, 2'd2};
        logic [7:0] va  [5] = '{8'h5A, 8'h77, 8'h01, 8'h80, 8'hFF};
        logic [7:0] vb  [5] = '{8'h3C, 8'h77, 8'hFF, 8'h01, 8'hFE};
        logic       egt [5];
        logic       eeq [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [3:0] exp_ack;
        egt[0] = 1'b1;
        egt[1] = 1'b0;
        egt[2] = 1'b0;
`ifdef CMP_ARB_SIGNED_EN
        egt[3] = 1'b0;
`else
        egt[3] = 1'b1;
`endif
        egt[4] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_a[ids[i]*8 +: 8] = va[i];
            req_b[ids[i]*8 +: 8] = vb[i];
            req[ids[i]]          = 1'b1;
            exp_ack              = 4'b0001 << ids[i];
            tick();
            tests++;
            if ({req_ack, busy} !== {exp_ack, 1'b1}) begin
                fails++;
                $display("FAIL cmp%0d_ack: got %b expected %b", i, {req_ack, busy}, {exp_ack, 1'b1});
            end
            req = '0;
            tick();
            tests++;
            if ({rsp_valid, rsp_id, rsp_gt, rsp_eq, req_ack} !== {1'b1, ids[i], egt[i], eeq[i], 4'b0}) begin
                fails++;
                $display("FAIL cmp%0d_rsp: got %b expected %b", i,
                         {rsp_valid, rsp_id, rsp_gt, rsp_eq, req_ack},
                         {1'b1, ids[i], egt[i], eeq[i], 4'b0});
            end
            tick();
            tests++;
            if ({rsp_valid, busy} !== 2'b00) begin
                fails++;
                $display("FAIL cmp%0d_done: got %b expected %b", i, {rsp_valid, busy}, 2'b00);
            end
        end
    endtask

    task automatic test_round_robin;
        logic [1:0] e;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            req_a[i*8 +: 8] = {i[3:0], 4'h0};
            req_b[i*8 +: 8] = 8'h20;
        end
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            e = 2'(g % 4);
            tick();
            tests++;
            if (req_ack !== (4'b0001 << e)) begin
                fails++;
                $display("FAIL rr%0d_ack: got %b expected %b", g, req_ack, 4'b0001 << e);
            end
            tick();
            tests++;
            if ({rsp_valid, rsp_id, rsp_gt, rsp_eq} !== {1'b1, e, (e > 2'd2), (e == 2'd2)}) begin
                fails++;
                $display("FAIL rr%0d_rsp: got %b expected %b", g,
                         {rsp_valid, rsp_id, rsp_gt, rsp_eq}, {1'b1, e, (e > 2'd2), (e == 2'd2)});
            end
            tick();
            tests++;
            if ({rsp_valid, req_ack} !== 5'b0) begin
                fails++;
                $display("FAIL rr%0d_gap: got %b expected %b", g, {rsp_valid, req_ack}, 5'b0);
            end
        end
        req = '0;
    endtask

    task automatic test_back_pressure;
        apply_reset();
        req_a[8 +: 8]  = 8'h10;
        req_b[8 +: 8]  = 8'h20;
        req_a[24 +: 8] = 8'h30;
        req_b[24 +: 8] = 8'h30;
        rsp_ready      = 1'b0;
        req            = 4'b1010;
        tick();
        tests++;
        if (req_ack !== 4'b0010) begin
            fails++;
            $display("FAIL bp_ack1: got %b expected %b", req_ack, 4'b0010);
        end
        req = 4'b1000;
        tick();
        for (int c = 0; c < 10; c++) begin
            tick();
            tests++;
            if ({rsp_valid, rsp_id, rsp_gt, rsp_eq, req_ack, busy} !== {1'b1, 2'd1, 1'b0, 1'b0, 4'b0, 1'b1}) begin
                fails++;
                $display("FAIL bp_hold%0d: got %b expected %b", c,
                         {rsp_valid, rsp_id, rsp_gt, rsp_eq, req_ack, busy},
                         {1'b1, 2'd1, 1'b0, 1'b0, 4'b0, 1'b1});
            end
        end
        rsp_ready = 1'b1;
        tick();
        tests++;
        if ({rsp_valid, busy} !== 2'b00) begin
            fails++;
            $display("FAIL bp_release: got %b expected %b", {rsp_valid, busy}, 2'b00);
        end
        tick();
        tests++;
        if (req_ack !== 4'b1000) begin
            fails++;
            $display("FAIL bp_ack3: got %b expected %b", req_ack, 4'b1000);
        end
        req = '0;
        tick();
        tests++;
        if ({rsp_valid, rsp_id, rsp_gt, rsp_eq} !== {1'b1, 2'd3, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL bp_rsp3: got %b expected %b",
                     {rsp_valid, rsp_id, rsp_gt, rsp_eq}, {1'b1, 2'd3, 1'b0, 1'b1});
        end
        tick();
    endtask

    task automatic test_reset_mid_op;
        apply_reset();
        req_a[8 +: 8]  = 8'hF0;
        req_b[8 +: 8]  = 8'h0F;
        req_a[24 +: 8] = 8'h00;
        req_b[24 +: 8] = 8'h01;
        req            = 4'b0010;
        tick();
        tests++;
        if ({req_ack, busy} !== 5'b00101) begin
            fails++;
            $display("FAIL rst_pre_ack: got %b expected %b", {req_ack, busy}, 5'b00101);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({req_ack, rsp_valid, rsp_id, rsp_gt, rsp_eq, busy} !== 10'b0) begin
            fails++;
            $display("FAIL rst_async: got %b expected %b",
                     {req_ack, rsp_valid, rsp_id, rsp_gt, rsp_eq, busy}, 10'b0);
        end
        tick();
        tests++;
        if ({rsp_valid, busy} !== 2'b00) begin
            fails++;
            $display("FAIL rst_hold: got %b expected %b", {rsp_valid, busy}, 2'b00);
        end
        req   = 4'b1010;
        rst_n = 1'b1;
        tick();
        tests++;
        if (req_ack !== 4'b0010) begin
            fails++;
            $display("FAIL rst_regrant: got %b expected %b", req_ack, 4'b0010);
        end
        req = 4'b1000;
        tick();
        tests++;
        if ({rsp_valid, rsp_id, rsp_gt, rsp_eq} !== {1'b1, 2'd1, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL rst_rsp: got %b expected %b",
                     {rsp_valid, rsp_id, rsp_gt, rsp_eq}, {1'b1, 2'd1, 1'b1, 1'b0});
        end
        req = '0;
        tick();
        tick();
    endtask

    initial begin
        req       = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        test_reset();
        test_compare();
        test_round_robin();
        test_back_pressure();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cmp_arbiter.md
# cmp_arbiter

Round-robin scheduler that shares a single `comparator` instance between `NUM_REQ` requesters in the 8-bit ALU datapath. Each requester presents an operand pair and holds a request until it is acknowledged. The arbiter grants one requester, latches its operands, and drives them through the shared comparator. It then returns a registered greater/equal result tagged with the requester's index over a valid/ready response channel.

## Interface
- `SIZE`, 8, operand width passed to the shared `comparator`.
- `NUM_REQ`, 4, number of requesters; 2..16.
- `ID_W`, `$clog2(NUM_REQ)`, width of requester index; derived, do not override.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  NUM_REQ  per-requester request; hold high with operands stable until matching `req_ack` bit.
- `req_a`  in  NUM_REQ*SIZE  operand A; requester i in bits [i*SIZE +: SIZE].
- `req_b`  in  NUM_REQ*SIZE  operand B; same packing as `req_a`.
- `req_ack`  out  NUM_REQ  one-hot, one-cycle pulse: operands of that requester captured.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts result when high with `rsp_valid`.
- `rsp_id`  out  ID_W  index of requester the result belongs to.
- `rsp_gt`  out  1  A > B.
- `rsp_eq`  out  1  A == B.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, COMPARE, RESPOND.
- IDLE: if `|req`, select a winner round-robin, searching upward from `last_grant+1` modulo NUM_REQ. At the edge: latch winner's A/B into `op_a`/`op_b`, latch `rsp_id`, set `last_grant`, pulse `req_ack[winner]`, and go to COMPARE. With no request, stay in IDLE.
- COMPARE: `op_a`/`op_b` drive the comparator. At the edge: register `is_a_greater`→`rsp_gt` and `equal`→`rsp_eq`, set `rsp_valid`, and go to RESPOND.
- RESPOND: hold `rsp_valid`, `rsp_id`, `rsp_gt`, `rsp_eq` stable. On `rsp_valid && rsp_ready`, clear `rsp_valid` and go to IDLE.
- No new grant is issued while in COMPARE or RESPOND. Pending requests wait; their operands must stay stable.
- A requester dropping `req` before being acked is legal; it is simply not granted.
- `rsp_gt` and `rsp_eq` are never both 1. Both 0 means A < B.
- The comparator is unsigned unless the macro below is defined.

## Timing
- All outputs are registered.
- Reset values: `req_ack`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_gt`=0, `rsp_eq`=0, `busy`=0, state=IDLE, `last_grant`=NUM_REQ-1 (requester 0 wins first), `op_a`/`op_b`=0.
- Request sampled in IDLE at edge N: `req_ack` high during cycle N+1, `rsp_valid` high from N+2.
- With `rsp_ready` tied high, `rsp_valid` lasts 1 cycle and IDLE is re-entered at N+3. Peak throughput is one comparison per 3 cycles.
- `req_ack` pulses are exactly one cycle and never overlap.
- Back-pressure: with `rsp_ready` low, the FSM stalls in RESPOND indefinitely with outputs frozen.
- Reset asserted mid-operation aborts immediately:
  - all outputs go to their reset values asynchronously;
  - no result is delivered for the in-flight request;
  - the requester re-arbitrates after reset.
- Round-robin pointer wrap: after granting NUM_REQ-1, the search starts at 0.

## Configuration
- `CMP_ARB_SIGNED_EN` defined: operands are two's complement. The MSB of both `op_a` and `op_b` is inverted before entering the comparator, so `rsp_gt` reflects a signed compare. `rsp_eq` is unaffected.
- Not defined: unsigned compare, operands passed straight through.

## Test plan
- Single request: SIZE=8, requester 2, A=0x5A, B=0x3C → `req_ack`=4'b0100 at N+1; `rsp_valid` at N+2 with `rsp_id`=2, `rsp_gt`=1, `rsp_eq`=0.
- Equal and less-than: A=B=0x77 → `rsp_eq`=1, `rsp_gt`=0. Then A=0x01, B=0xFF unsigned → both 0.
- Round-robin fairness: all 4 requesters held continuously, `rsp_ready`=1 → grant order 0,1,2,3,0. One `rsp_valid` every 3 cycles, `rsp_id` matches the grant order.
- Back-pressure: `rsp_ready`=0 for 10 cycles → `rsp_valid`, `rsp_id`, and result stable throughout, no `req_ack` while held. Release → returns to IDLE next cycle, next grant follows.
- Reset mid-operation: assert `rst_n`=0 in COMPARE → outputs immediately 0, `busy`=0. After release with requesters 1 and 3 pending → requester 1 granted first.
- Signed build (`CMP_ARB_SIGNED_EN`): A=0x80 (−128), B=0x01 → `rsp_gt`=0. Unsigned build with the same stimulus → `rsp_gt`=1.
